// File: rtl/align_accumulate_if.sv
// Window-in / result-out handshake bundle for the mantissa alignment and accumulation stage.
// The master side issues windows and takes results; the slave side is the accumulator.
interface align_accumulate_if #(
  parameter int MAN_W = 12,
  parameter int ACC_W = MAN_W + 7
);
  logic                    in_valid;
  logic                    in_ready;
  logic [44:0]             exp_in;
  logic [9*MAN_W-1:0]      man_in;
  logic [4:0]              exp_max;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        sum_out;
  logic [4:0]              exp_out;
  logic                    align_err;

  modport master (
    output in_valid, exp_in, man_in, exp_max, out_ready,
    input  in_ready, out_valid, sum_out, exp_out, align_err
  );

  modport slave (
    input  in_valid, exp_in, man_in, exp_max, out_ready,
    output in_ready, out_valid, sum_out, exp_out, align_err
  );
endinterface

// File: rtl/align_accumulate.sv
// Captures a 3x3 window of product terms, aligns each mantissa to the common maximum
// exponent and accumulates one term per cycle, then offers the sum downstream.
module align_accumulate #(
  parameter int MAN_W = 12,
  parameter int GRD_W = 3,
  parameter int ACC_W = MAN_W + GRD_W + 4
) (
  input logic               clk,
  input logic               rst_n,
  align_accumulate_if.slave bus
);
  localparam int TERMS = 9;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state_reg;
  logic [5*TERMS-1:0]      exp_reg;
  logic [MAN_W*TERMS-1:0]  man_reg;
  logic [4:0]              exp_max_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [3:0]              idx_reg;
  logic                    err_reg;

  logic [4:0]              exp_term [TERMS];
  logic [MAN_W-1:0]        man_term [TERMS];

  generate
    for (genvar gi = 0; gi < TERMS; gi++) begin : g_unpack
      assign exp_term[gi] = exp_reg[5*gi +: 5];
      assign man_term[gi] = man_reg[MAN_W*gi +: MAN_W];
    end
  endgenerate

  logic [4:0]              exp_sel;
  logic [MAN_W-1:0]        man_sel;
  logic                    over_sel;
  logic [4:0]              diff;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] aligned;
  logic signed [ACC_W-1:0] acc_next;

  always_comb begin
    exp_sel = '0;
    man_sel = '0;
    for (int i = 0; i < TERMS; i++) begin
      if (idx_reg == 4'(i)) begin
        exp_sel = exp_term[i];
        man_sel = man_term[i];
      end
    end
  end

  // A term above the claimed maximum is flagged and added unshifted.
  assign over_sel = (exp_sel > exp_max_reg);
  assign diff     = over_sel ? 5'd0 : (exp_max_reg - exp_sel);
  assign ext      = {{(ACC_W-MAN_W-GRD_W){man_sel[MAN_W-1]}}, man_sel, {GRD_W{1'b0}}};
  // Shifts past the width saturate to the sign, giving 0 or -1 as required.
  assign aligned  = ext >>> diff;
  assign acc_next = acc_reg + aligned;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      exp_reg     <= '0;
      man_reg     <= '0;
      exp_max_reg <= '0;
      acc_reg     <= '0;
      idx_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            exp_reg     <= bus.exp_in;
            man_reg     <= bus.man_in;
            exp_max_reg <= bus.exp_max;
            acc_reg     <= '0;
            idx_reg     <= '0;
            err_reg     <= 1'b0;
            state_reg   <= ACC;
          end
        end
        ACC: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + 4'd1;
          if (over_sel) begin
            err_reg <= 1'b1;
          end
          if (idx_reg == 4'(TERMS - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.sum_out   = acc_reg;
  assign bus.exp_out   = exp_max_reg;
  assign bus.align_err = err_reg;
endmodule

// File: tb/tb_align_accumulate.sv
// Randomised and directed windows against a real-arithmetic reference model; a monitor
// pops expected results from a scoreboard whenever the block hands one off.
module tb_align_accumulate;
  localparam int MAN_W = 12;
  localparam int GRD_W = 3;
  localparam int ACC_W = MAN_W + GRD_W + 4;
  localparam int TERMS = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  align_accumulate_if #(.MAN_W(MAN_W), .ACC_W(ACC_W)) bus ();

  align_accumulate #(.MAN_W(MAN_W), .GRD_W(GRD_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    longint sum;
    longint ex;
    longint err;
  } res_t;

  res_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  longint cycle = 0;
  longint accept_cyc = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Value of each term is man * 2^GRD_W / 2^diff, rounded toward minus infinity.
  function automatic res_t model(input int ex[TERMS], input int mn[TERMS], input int emax);
    res_t r;
    real  total;
    int   d;
    total = 0.0;
    r.err = 0;
    for (int i = 0; i < TERMS; i++) begin
      d = emax - ex[i];
      if (d < 0) begin
        d = 0;
        r.err = 1;
      end
      total = total + $floor(real'(mn[i] * (2 ** GRD_W)) / (2.0 ** d));
    end
    r.sum = longint'(total);
    r.ex  = emax;
    return r;
  endfunction

  task automatic drive(input int ex[TERMS], input int mn[TERMS], input int emax);
    for (int i = 0; i < TERMS; i++) begin
      bus.exp_in[5*i +: 5]         = 5'(ex[i]);
      bus.man_in[MAN_W*i +: MAN_W] = MAN_W'(mn[i]);
    end
    bus.exp_max = 5'(emax);
  endtask

  task automatic scramble();
    int ex[TERMS];
    int mn[TERMS];
    for (int i = 0; i < TERMS; i++) begin
      ex[i] = int'($urandom_range(0, 31));
      mn[i] = int'($urandom_range(0, 4095));
    end
    drive(ex, mn, int'($urandom_range(0, 31)));
    bus.in_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic run_window(input int ex[TERMS], input int mn[TERMS], input int emax, input int stall);
    res_t r;
    int   n;
    r = model(ex, mn, emax);
    @(negedge clk);
    drive(ex, mn, emax);
    bus.in_valid = 1'b1;
    chk("in_ready_idle", longint'(bus.in_ready), 1);
    sb.push_back(r);
    @(negedge clk);
    accept_cyc = cycle;
    scramble();
    chk("in_ready_busy", longint'(bus.in_ready), 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      scramble();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < stall; k++) begin
      chk("stall_valid", longint'(bus.out_valid), 1);
      chk("stall_in_ready", longint'(bus.in_ready), 0);
      chk("stall_sum", longint'($signed(bus.sum_out)), r.sum);
      chk("stall_exp", longint'(bus.exp_out), r.ex);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("in_ready_after", longint'(bus.in_ready), 1);
    chk("out_valid_after", longint'(bus.out_valid), 0);
  endtask

  // Monitor: compare every handed-off result and the accept-to-valid latency.
  initial begin
    res_t exp_r;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.out_valid && !prev_valid) begin
        chk("latency", cycle - accept_cyc, 9);
      end
      prev_valid = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_r = sb.pop_front();
          chk("sum_out", longint'($signed(bus.sum_out)), exp_r.sum);
          chk("exp_out", longint'(bus.exp_out), exp_r.ex);
          chk("align_err", longint'(bus.align_err), exp_r.err);
          $display("xfer sum=%0d exp=%0d err=%0d", $signed(bus.sum_out), bus.exp_out, bus.align_err);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ex[TERMS];
    int mn[TERMS];
    int emax;
    int m;

    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.exp_in    = '0;
    bus.man_in    = '0;
    bus.exp_max   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_sum", longint'($signed(bus.sum_out)), 0);
    chk("rst_exp", longint'(bus.exp_out), 0);
    chk("rst_err", longint'(bus.align_err), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < TERMS; i++) begin ex[i] = 15; mn[i] = 1024; end
    run_window(ex, mn, 15, 0);

    for (int i = 0; i < TERMS; i++) begin ex[i] = 0; mn[i] = 0; end
    ex[0] = 15; mn[0] = 1024; ex[1] = 13; mn[1] = 1024;
    run_window(ex, mn, 15, 1);

    for (int i = 0; i < TERMS; i++) begin ex[i] = 0; mn[i] = 0; end
    ex[0] = 10; mn[0] = -1; ex[1] = 0; mn[1] = 5;
    run_window(ex, mn, 15, 0);

    for (int i = 0; i < TERMS; i++) begin ex[i] = 0; mn[i] = 0; end
    mn[0] = -2048;
    run_window(ex, mn, 20, 5);

    // Reset in the middle of accumulation discards the window.
    for (int i = 0; i < TERMS; i++) begin ex[i] = 15; mn[i] = 1024; end
    @(negedge clk);
    drive(ex, mn, 15);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_in_ready", longint'(bus.in_ready), 1);
    chk("midrst_sum", longint'($signed(bus.sum_out)), 0);
    for (int i = 0; i < TERMS; i++) begin ex[i] = 3; mn[i] = 8; end
    run_window(ex, mn, 3, 0);

    for (int i = 0; i < TERMS; i++) begin ex[i] = 0; mn[i] = 0; end
    ex[2] = 20; mn[2] = 100;
    run_window(ex, mn, 18, 2);
    for (int i = 0; i < TERMS; i++) begin ex[i] = 7; mn[i] = -300 + 70 * i; end
    run_window(ex, mn, 9, 0);

    for (int t = 0; t < 30; t++) begin
      m = 0;
      for (int i = 0; i < TERMS; i++) begin
        ex[i] = int'($urandom_range(0, 31));
        mn[i] = int'($urandom_range(0, 4095)) - 2048;
        if (ex[i] > m) m = ex[i];
      end
      emax = m;
      if ($urandom_range(0, 3) == 0) emax = int'($urandom_range(0, m));
      run_window(ex, mn, emax, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
